// File: rtl/local_mem_bank_arbiter.sv
// local_mem_bank_arbiter: round-robin sharing of one Avalon-MM local memory bank
// among NUM_REQ requesters. A write burst keeps the grant until its last beat.
// Read response beats are routed to the issuing requester through an in-order
// FIFO of {id, burstcount}. The command and response paths are combinational.
// Optional statistics counters are enabled with `define LOCAL_MEM_ARB_STATS_EN.
module local_mem_bank_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RSP_FIFO_DEPTH  = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_read_i,
    input  logic [NUM_REQ-1:0]         req_write_i,
    input  logic [ADDR_WIDTH-1:0]      req_address_i    [NUM_REQ],
    input  logic [BURST_CNT_WIDTH-1:0] req_burstcount_i [NUM_REQ],
    input  logic [DATA_WIDTH-1:0]      req_writedata_i  [NUM_REQ],
    input  logic [DATA_WIDTH/8-1:0]    req_byteenable_i [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_waitrequest_o,
    output logic [NUM_REQ-1:0]         req_readdatavalid_o,
    output logic [DATA_WIDTH-1:0]      req_readdata_o,
    output logic                       mem_read_o,
    output logic                       mem_write_o,
    output logic [ADDR_WIDTH-1:0]      mem_address_o,
    output logic [BURST_CNT_WIDTH-1:0] mem_burstcount_o,
    output logic [DATA_WIDTH-1:0]      mem_writedata_o,
    output logic [DATA_WIDTH/8-1:0]    mem_byteenable_o,
    input  logic                       mem_waitrequest_i,
    input  logic                       mem_readdatavalid_i,
`ifdef LOCAL_MEM_ARB_STATS_EN
    output logic [31:0]                grant_count_o    [NUM_REQ],
    output logic [31:0]                fifo_full_cycles_o,
`endif
    input  logic [DATA_WIDTH-1:0]      mem_readdata_i
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_ARB     = 1'b0;
    localparam logic [0:0] ST_WR_LOCK = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [ID_W-1:0]            win_q, win_d;
    logic [BURST_CNT_WIDTH-1:0] wr_left_q, wr_left_d;

    logic [ID_W-1:0]            fifo_id_q [RSP_FIFO_DEPTH];
    logic [BURST_CNT_WIDTH-1:0] fifo_bc_q [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]           fifo_wp_q, fifo_rp_q;
    logic [CNT_W-1:0]           fifo_cnt_q;
    logic [BURST_CNT_WIDTH-1:0] rsp_cnt_q, rsp_cnt_d;

    logic [ID_W-1:0]            arb_win, sel;
    logic                       arb_any, sel_vld, sel_rd, sel_wr;
    logic                       fifo_full, fifo_empty, rd_blocked;
    logic                       rd_acc, wr_acc, push, pop, rsp_beat, rsp_last;
    logic [BURST_CNT_WIDTH-1:0] bc_eff, head_bc;
    logic [ID_W-1:0]            head_id;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Round-robin search: first requesting port at or after ptr, wrapping
    always_comb begin
        int unsigned idx;
        arb_win = ptr_q;
        arb_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!arb_any && (req_read_i[ID_W'(idx)] || req_write_i[ID_W'(idx)])) begin
                arb_any = 1'b1;
                arb_win = ID_W'(idx);
            end
        end
    end

    // Pick the passed-through requester: locked writer or the round-robin winner
    always_comb begin
        if (state_q == ST_WR_LOCK) begin
            sel     = win_q;
            sel_vld = req_write_i[win_q];
        end else begin
            sel     = arb_win;
            sel_vld = arb_any;
        end
    end

    assign fifo_full  = (fifo_cnt_q == CNT_W'(RSP_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign sel_wr     = sel_vld && req_write_i[sel];
    assign sel_rd     = sel_vld && (state_q == ST_ARB) && req_read_i[sel] && !req_write_i[sel];
    assign rd_blocked = sel_rd && fifo_full;
    assign bc_eff     = (req_burstcount_i[sel] == '0) ? BURST_CNT_WIDTH'(1) : req_burstcount_i[sel];

    assign mem_read_o       = !reset_i && sel_rd && !fifo_full;
    assign mem_write_o      = !reset_i && sel_wr;
    assign mem_address_o    = req_address_i[sel];
    assign mem_burstcount_o = req_burstcount_i[sel];
    assign mem_writedata_o  = req_writedata_i[sel];
    assign mem_byteenable_o = req_byteenable_i[sel];
    assign req_readdata_o   = mem_readdata_i;

    assign rd_acc = mem_read_o && !mem_waitrequest_i;
    assign wr_acc = mem_write_o && !mem_waitrequest_i;
    assign push   = rd_acc;

    assign head_id  = fifo_id_q[fifo_rp_q];
    assign head_bc  = fifo_bc_q[fifo_rp_q];
    assign rsp_beat = mem_readdatavalid_i && !fifo_empty;
    assign rsp_last = (({1'b0, rsp_cnt_q} + 1'b1) == {1'b0, head_bc});
    assign pop      = rsp_beat && rsp_last;

    // Per-requester stall and response-valid fan-out
    always_comb begin
        req_waitrequest_o   = '1;
        req_readdatavalid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!reset_i && sel_vld && (sel == ID_W'(i)))
                req_waitrequest_o[i] = mem_waitrequest_i || rd_blocked;
            if (!reset_i && rsp_beat && (head_id == ID_W'(i)))
                req_readdatavalid_o[i] = 1'b1;
        end
    end

    // Grant state: pointer advance on accepted commands, write-burst lock
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        wr_left_d = wr_left_q;
        if (state_q == ST_ARB) begin
            if (rd_acc) begin
                ptr_d = next_id(sel);
            end else if (wr_acc) begin
                if (bc_eff == BURST_CNT_WIDTH'(1)) begin
                    ptr_d = next_id(sel);
                end else begin
                    wr_left_d = bc_eff - 1'b1;
                    win_d     = sel;
                    state_d   = ST_WR_LOCK;
                end
            end
        end else if (wr_acc) begin
            wr_left_d = wr_left_q - 1'b1;
            if (wr_left_q == BURST_CNT_WIDTH'(1)) begin
                ptr_d   = next_id(win_q);
                state_d = ST_ARB;
            end
        end
    end

    // Response beat counter within the head burst
    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        if (rsp_beat) rsp_cnt_d = pop ? '0 : rsp_cnt_q + 1'b1;
    end

    // Control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            win_q      <= '0;
            wr_left_q  <= '0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            wr_left_q  <= wr_left_d;
            rsp_cnt_q  <= rsp_cnt_d;
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push) fifo_wp_q <= fifo_wp_q + 1'b1;
            if (pop)  fifo_rp_q <= fifo_rp_q + 1'b1;
        end
    end

    // Routing FIFO storage; zero burstcount is stored as 1 so the counter always terminates
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id_q[fifo_wp_q] <= sel;
            fifo_bc_q[fifo_wp_q] <= bc_eff;
        end
    end

`ifdef LOCAL_MEM_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] full_cyc_q;
    logic        cmd_start;

    assign cmd_start          = (state_q == ST_ARB) && (rd_acc || wr_acc);
    assign grant_count_o      = grant_cnt_q;
    assign fifo_full_cycles_o = full_cyc_q;

    // Saturating statistics: commands granted per requester, cycles lost to a full FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            full_cyc_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
                if (cmd_start && (sel == ID_W'(i)) && (grant_cnt_q[i] != '1))
                    grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
            if (rd_blocked && (full_cyc_q != '1)) full_cyc_q <= full_cyc_q + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A response beat with nothing outstanding has no owner; it is dropped
    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_readdatavalid_i && fifo_empty))
        else $error("local_mem_bank_arbiter: readdatavalid with empty routing FIFO");
`endif

endmodule

// File: tb/tb_local_mem_bank_arbiter.sv
// Self-checking bench for local_mem_bank_arbiter (3 requesters, 4-entry routing FIFO).
module tb_local_mem_bank_arbiter;

    localparam int N  = 3;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  rd, wr, wreq, rdv;
    logic [AW-1:0] addr [N];
    logic [BW-1:0] bc   [N];
    logic [DW-1:0] wd   [N];
    logic [DW/8-1:0] be [N];
    logic [DW-1:0] rdata, m_rdata, m_wd;
    logic          m_rd, m_wr, m_wait, m_rdv;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_bc;
    logic [DW/8-1:0] m_be;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    local_mem_bank_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_CNT_WIDTH(BW), .RSP_FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_read_i(rd), .req_write_i(wr),
        .req_address_i(addr), .req_burstcount_i(bc),
        .req_writedata_i(wd), .req_byteenable_i(be),
        .req_waitrequest_o(wreq), .req_readdatavalid_o(rdv), .req_readdata_o(rdata),
        .mem_read_o(m_rd), .mem_write_o(m_wr), .mem_address_o(m_addr),
        .mem_burstcount_o(m_bc), .mem_writedata_o(m_wd), .mem_byteenable_o(m_be),
        .mem_waitrequest_i(m_wait), .mem_readdatavalid_i(m_rdv),
        .mem_readdata_i(m_rdata)
    );

    // Reference model: round-robin pointer, write-burst ownership, per-beat owner queue
    typedef struct { int id; bit last; } beat_t;
    beat_t mq[$];
    int    mp, mlid, mleft, mbursts;
    bit    mlock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int g, n;
        bit gv, is_rd, is_wr, full;
        logic [N-1:0] e_wreq, e_rdv;
        #1;
        g = 0; gv = 0;
        if (mlock) begin
            g = mlid; gv = wr[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mp + k) % N;
                if (!gv && (rd[j] || wr[j])) begin g = j; gv = 1; end
            end
        end
        is_wr = gv && wr[g];
        is_rd = gv && !mlock && rd[g] && !wr[g];
        full  = (mbursts == D);
        if (reset) begin is_wr = 0; is_rd = 0; gv = 0; end
        e_wreq = '1;
        if (gv) e_wreq[g] = m_wait || (is_rd && full);
        e_rdv = '0;
        if (!reset && m_rdv && mq.size() > 0) e_rdv[mq[0].id] = 1'b1;
        chk("mem_read", 64'(m_rd), 64'(is_rd && !full));
        chk("mem_write", 64'(m_wr), 64'(is_wr));
        chk("waitrequest", 64'(wreq), 64'(e_wreq));
        chk("readdatavalid", 64'(rdv), 64'(e_rdv));
        if (e_rdv != '0) chk("readdata", 64'(rdata), 64'(m_rdata));
        if ((is_rd && !full) || is_wr) begin
            chk("mem_address", 64'(m_addr), 64'(addr[g]));
            chk("mem_burstcount", 64'(m_bc), 64'(bc[g]));
        end
        if (is_wr) begin
            chk("mem_writedata", 64'(m_wd), 64'(wd[g]));
            chk("mem_byteenable", 64'(m_be), 64'(be[g]));
        end
        @(posedge clk);
        if (reset) begin
            mp = 0; mlock = 0; mleft = 0; mbursts = 0; mq.delete();
        end else begin
            if (!m_wait && is_rd && !full) begin
                n = (bc[g] == 0) ? 1 : int'(bc[g]);
                for (int b = 0; b < n; b++) mq.push_back('{id: g, last: (b == n - 1)});
                mbursts++;
                mp = (g + 1) % N;
            end
            if (!m_wait && is_wr) begin
                if (mlock) begin
                    mleft--;
                    if (mleft == 0) begin mlock = 0; mp = (g + 1) % N; end
                end else begin
                    n = (bc[g] == 0) ? 1 : int'(bc[g]);
                    if (n == 1) mp = (g + 1) % N;
                    else begin mlock = 1; mlid = g; mleft = n - 1; end
                end
            end
            if (m_rdv && mq.size() > 0) begin
                if (mq[0].last) mbursts--;
                void'(mq.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd = '0; wr = '0; m_wait = 1'b0; m_rdv = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int t = 0; t < 64 && mq.size() > 0; t++) begin
            m_rdv = 1'b1; m_rdata = $urandom;
            step();
        end
        m_rdv = 1'b0;
    endtask

    typedef struct {
        logic rst; logic [N-1:0] rd, wr; logic wt;
        logic e_rd, e_wr; logic [N-1:0] e_wreq; int e_id;
    } vec_t;
    vec_t tbl [9];

    int beat;

    initial begin
        tbl[0] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b111, -1};
        tbl[1] = '{1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 3'b110,  0};
        tbl[2] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 3'b101,  1};
        tbl[3] = '{1'b0, 3'b100, 3'b000, 1'b1, 1'b1, 1'b0, 3'b111,  2};
        tbl[4] = '{1'b0, 3'b010, 3'b100, 1'b0, 1'b1, 1'b0, 3'b101,  1};
        tbl[5] = '{1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 1'b1, 3'b110,  0};
        tbl[6] = '{1'b0, 3'b000, 3'b110, 1'b0, 1'b0, 1'b1, 3'b101,  1};
        tbl[7] = '{1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 1'b1, 3'b111,  2};
        tbl[8] = '{1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b111, -1};

        mp = 0; mlock = 0; mleft = 0; mlid = 0; mbursts = 0;
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'(100 + i); bc[i] = 4'd1; wd[i] = DW'(i); be[i] = '1;
        end
        m_rdata = '0;
        @(negedge clk);

        // Reset state: requests and a stray response are ignored during reset
        reset = 1'b1; idle_inputs(); rd = 3'b111; m_rdv = 1'b1;
        #1;
        chk("reset_mem_read", 64'(m_rd), 64'(0));
        chk("reset_wreq", 64'(wreq), 64'(3'b111));
        chk("reset_rdv", 64'(rdv), 64'(0));
        step();
        do_reset();

        // Single-cycle arbitration from a fresh reset (ptr = 0)
        for (int v = 0; v < 9; v++) begin
            do_reset();
            reset = tbl[v].rst; rd = tbl[v].rd; wr = tbl[v].wr; m_wait = tbl[v].wt;
            for (int i = 0; i < N; i++) bc[i] = 4'd1;
            #1;
            chk("tbl_mem_read", 64'(m_rd), 64'(tbl[v].e_rd));
            chk("tbl_mem_write", 64'(m_wr), 64'(tbl[v].e_wr));
            chk("tbl_wreq", 64'(wreq), 64'(tbl[v].e_wreq));
            if (tbl[v].e_id >= 0) chk("tbl_addr", 64'(m_addr), 64'(100 + tbl[v].e_id));
            step();
            reset = 1'b0;
        end
        do_reset();

        // Two requesters reading every cycle alternate, responses go to their owners
        rd = 3'b011; bc[0] = 4'd1; bc[1] = 4'd1;
        for (int k = 0; k < 6; k++) begin
            m_rdv = (k > 0); m_rdata = DW'(k);
            #1;
            chk("rr_grant", 64'(m_addr), 64'(100 + (k % 2)));
            if (k > 0) chk("rr_rdv", 64'(rdv), (k % 2) ? 64'(3'b001) : 64'(3'b010));
            step();
        end
        drain();

        // 4-beat write by 0 holds off a read by 1 until the beat after the burst
        do_reset();
        wr = 3'b001; bc[0] = 4'd4; rd = 3'b010; bc[1] = 4'd1;
        for (int k = 0; k < 5; k++) begin
            wd[0] = DW'(32'hA0 + k);
            #1;
            if (k < 4) begin
                chk("wlock_wreq1", 64'(wreq[1]), 64'(1));
                chk("wlock_write", 64'(m_wr), 64'(1));
                chk("wlock_addr", 64'(m_addr), 64'(100));
            end else begin
                chk("wlock_next_read", 64'(m_rd), 64'(1));
                chk("wlock_next_addr", 64'(m_addr), 64'(101));
            end
            step();
        end
        drain();

        // Bank stall mid-burst freezes the remaining-beat count
        do_reset();
        wr = 3'b001; bc[0] = 4'd3; rd = 3'b010; beat = 0;
        for (int k = 0; k < 9; k++) begin
            m_wait = (k >= 1 && k <= 5);
            wd[0] = DW'(32'hB0 + beat);
            #1;
            if (k <= 7) begin
                chk("stall_wreq1", 64'(wreq[1]), 64'(1));
                chk("stall_write", 64'(m_wr), 64'(1));
                chk("stall_data", 64'(m_wd), 64'(32'hB0 + beat));
            end else begin
                chk("stall_release", 64'(m_rd), 64'(1));
                chk("stall_release_addr", 64'(m_addr), 64'(101));
            end
            step();
            if (!m_wait) beat++;
        end
        drain();

        // Full routing FIFO blocks reads but not writes
        do_reset();
        rd = 3'b001; bc[0] = 4'd2;
        for (int k = 0; k < 4; k++) begin
            #1; chk("fill_read", 64'(m_rd), 64'(1));
            step();
        end
        wr = 3'b010; bc[1] = 4'd1;
        #1;
        chk("full_write_passes", 64'(m_wr), 64'(1));
        chk("full_write_addr", 64'(m_addr), 64'(101));
        chk("full_wreq0", 64'(wreq[0]), 64'(1));
        step();
        wr = '0;
        for (int k = 0; k < 2; k++) begin
            m_rdv = 1'b1; m_rdata = DW'(k);
            #1;
            chk("full_blocked", 64'(m_rd), 64'(0));
            chk("full_wreq0_blk", 64'(wreq[0]), 64'(1));
            chk("full_rsp0", 64'(rdv), 64'(3'b001));
            step();
        end
        m_rdv = 1'b0;
        #1; chk("full_unblocked", 64'(m_rd), 64'(1));
        step();
        drain();

        // Burst-8 read by 1 then burst-2 read by 0: beats routed in issue order
        do_reset();
        rd = 3'b010; bc[1] = 4'd8;
        step();
        rd = 3'b001; bc[0] = 4'd2;
        #1; chk("order_grant0", 64'(m_addr), 64'(100));
        step();
        rd = '0;
        for (int k = 0; k < 10; k++) begin
            m_rdv = 1'b1; m_rdata = DW'(32'hC00 + k);
            #1; chk("order_rdv", 64'(rdv), (k < 8) ? 64'(3'b010) : 64'(3'b001));
            step();
        end
        m_rdv = 1'b0;

        // Reset during the 2nd beat of a write burst with a read outstanding
        do_reset();
        rd = 3'b001; bc[0] = 4'd1;
        step();
        rd = '0; wr = 3'b010; bc[1] = 4'd4;
        #1; chk("rst_burst_start", 64'(m_wr), 64'(1));
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_write", 64'(m_wr), 64'(0));
        chk("rst_mid_wreq", 64'(wreq), 64'(3'b111));
        step();
        reset = 1'b0; wr = '0; rd = 3'b011; bc[1] = 4'd1;
        #1;
        chk("rst_regrant", 64'(m_rd), 64'(1));
        chk("rst_regrant_addr", 64'(m_addr), 64'(100));
        step();
        drain();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                rd[i] = (r < 3);
                wr[i] = (r >= 3 && r < 6);
                addr[i] = AW'($urandom);
                bc[i] = BW'($urandom_range(0, 5));
                wd[i] = $urandom;
                be[i] = 4'($urandom);
            end
            m_wait = ($urandom_range(0, 3) == 0);
            m_rdv = !reset && (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;
            step();
        end
        reset = 1'b0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
